// File: rtl/shift_frame_arbiter.sv
// Round-robin owner of a shared load/shift register: grants one requester,
// loads its word, then tracks WIDTH serial bits with an optional idle gap.
module shift_frame_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         gnt,
  output logic [WIDTH-1:0]     sh_data,
  output logic                 sh_load,
  output logic                 bit_valid,
  output logic                 exp_bit,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned SW = PW + 1;
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner_q;
  logic [WIDTH-1:0] data_q;
  logic [BW-1:0]    bcnt;
  logic [GW-1:0]    gcnt;

  logic [SW-1:0]    sum;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    win;
  logic             found;
  logic [WIDTH-1:0] load_word;
  logic             last_bit;

  // First pending requester at or after the pointer, wrapping modulo N
  always_comb begin
    win   = ptr;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      cand = PW'(sum);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Winner's word taken straight from the request bus during LOAD
  always_comb begin
    load_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner_q == PW'(i)) load_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign last_bit = (bcnt == BW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    gnt       = '0;
    sh_data   = data_q;
    sh_load   = 1'b0;
    bit_valid = 1'b0;
    exp_bit   = 1'b0;
    owner     = owner_q;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) state_d = S_LOAD;
      end
      S_LOAD: begin
        gnt     = N'(1) << owner_q;
        sh_data = load_word;
        sh_load = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bit_valid = 1'b1;
        exp_bit   = data_q[BW'(WIDTH - 1) - bcnt];
        done      = last_bit;
        if (last_bit) state_d = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gcnt == GW'(GAP - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame datapath: owner, captured word, rotation pointer and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= '0;
      owner_q <= '0;
      data_q  <= '0;
      bcnt    <= '0;
      gcnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) owner_q <= win;
        end
        S_LOAD: begin
          data_q <= load_word;
          bcnt   <= '0;
          ptr    <= (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
        end
        S_SHIFT: begin
          bcnt <= bcnt + 1'b1;
          gcnt <= '0;
        end
        S_GAP: begin
          gcnt <= gcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_frame_arbiter.sv
// Scoreboard bench: a frame-level arbitration model predicts grants and bit
// streams; a negedge monitor pops and compares what the arbiter presents.
module tb_shift_frame_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int GAP   = 1;
  localparam int PW    = $clog2(N);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset_n;
  logic [N-1:0]         want;
  logic [WIDTH-1:0]     words [N];
  logic [N*WIDTH-1:0]   req_data;
  logic [N-1:0]         gnt;
  logic [WIDTH-1:0]     sh_data;
  logic                 sh_load, bit_valid, exp_bit, busy, done;
  logic [PW-1:0]        owner;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*WIDTH +: WIDTH] = words[i];
  end

  shift_frame_arbiter #(.N(N), .WIDTH(WIDTH), .GAP(GAP)) u_dut (
    .clock(clock), .reset_n(reset_n), .req(want), .req_data(req_data),
    .gnt(gnt), .sh_data(sh_data), .sh_load(sh_load), .bit_valid(bit_valid),
    .exp_bit(exp_bit), .owner(owner), .busy(busy), .done(done)
  );

  // Second instance built with no gap, requester 0 always asking
  logic                 rst0_n;
  logic [N-1:0]         req0;
  logic [N*WIDTH-1:0]   data0;
  logic [N-1:0]         gnt0;
  logic [WIDTH-1:0]     sh_data0;
  logic                 sh_load0, bit_valid0, exp_bit0, busy0, done0;
  logic [PW-1:0]        owner0;

  shift_frame_arbiter #(.N(N), .WIDTH(WIDTH), .GAP(0)) u_dut_gap0 (
    .clock(clock), .reset_n(rst0_n), .req(req0), .req_data(data0),
    .gnt(gnt0), .sh_data(sh_data0), .sh_load(sh_load0), .bit_valid(bit_valid0),
    .exp_bit(exp_bit0), .owner(owner0), .busy(busy0), .done(done0)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // External loadshift register, MSB shifted out first
  logic [WIDTH-1:0] shreg;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)     shreg <= '0;
    else if (sh_load) shreg <= sh_data;
    else              shreg <= shreg << 1;
  end

  typedef struct {
    int               load_cyc;
    int               w;
    logic [WIDTH-1:0] word;
  } frame_t;

  frame_t exp_q[$];
  int     idle_from;
  int     ptr_m;
  int     clr_at;
  int     clr_idx;
  bit     hold_mode;

  // Arbiter is free from idle_from on; a decision made now loads next cycle
  task automatic model_eval();
    if (reset_n && cyc >= idle_from && want != '0) begin
      int w;
      w = -1;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (ptr_m + i) % N;
        if (w < 0 && want[j]) w = j;
      end
      exp_q.push_back('{cyc + 1, w, words[w]});
      ptr_m     = (w + 1) % N;
      idle_from = cyc + 2 + WIDTH + GAP;
      clr_at    = cyc + 2;
      clr_idx   = w;
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
    if (cyc == clr_at && !hold_mode) want[clr_idx] = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      adv();
      model_eval();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},     32'(gnt),       32'd0);
    chk({tag, "_sh_data"}, 32'(sh_data),   32'd0);
    chk({tag, "_sh_load"}, 32'(sh_load),   32'd0);
    chk({tag, "_bvalid"},  32'(bit_valid), 32'd0);
    chk({tag, "_exp_bit"}, 32'(exp_bit),   32'd0);
    chk({tag, "_owner"},   32'(owner),     32'd0);
    chk({tag, "_busy"},    32'(busy),      32'd0);
    chk({tag, "_done"},    32'(done),      32'd0);
  endtask

  // Monitor
  frame_t           cur;
  bit               have;
  bit               mon_active;
  int               k;
  logic [PW-1:0]    mon_owner;
  logic [WIDTH-1:0] mon_data;

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      have       = 1'b0;
      mon_active = 1'b0;
      k          = 0;
      mon_owner  = '0;
      mon_data   = '0;
    end else begin
      bit exp_busy;
      bit exp_bv;
      if (sh_load) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant_cycle", 32'(cyc), 32'(cur.load_cyc));
          chk("gnt",         32'(gnt), 32'(1 << cur.w));
          chk("owner_load",  32'(owner), 32'(cur.w));
          chk("sh_data_load", 32'(sh_data), 32'(cur.word));
          have       = 1'b1;
          mon_active = 1'b1;
          k          = 0;
          mon_owner  = PW'(cur.w);
          mon_data   = cur.word;
        end
      end else begin
        chk("gnt_idle", 32'(gnt), 32'd0);
        if (exp_q.size() != 0 && exp_q[0].load_cyc <= cyc) begin
          chk("missed_grant", 32'(cyc), 32'(exp_q[0].load_cyc));
          void'(exp_q.pop_front());
        end
        chk("owner_hold",   32'(owner),   32'(mon_owner));
        chk("sh_data_hold", 32'(sh_data), 32'(mon_data));
      end
      exp_busy = have && cyc >= cur.load_cyc && cyc <= cur.load_cyc + WIDTH + GAP;
      exp_bv   = have && cyc >= cur.load_cyc + 1 && cyc <= cur.load_cyc + WIDTH;
      chk("busy",      32'(busy),      32'(exp_busy));
      chk("bit_valid", 32'(bit_valid), 32'(exp_bv));
      if (bit_valid && exp_bv && k < WIDTH) begin
        chk("exp_bit",     32'(exp_bit),         32'(cur.word[WIDTH-1-k]));
        chk("shifter_out", 32'(shreg[WIDTH-1]),  32'(cur.word[WIDTH-1-k]));
        chk("done",        32'(done),            32'(k == WIDTH - 1));
        k++;
        if (k == WIDTH) mon_active = 1'b0;
      end else begin
        chk("done_idle",    32'(done),    32'd0);
        chk("exp_bit_idle", 32'(exp_bit), 32'd0);
      end
    end
  end

  // No-gap instance: one idle cycle between frames, period WIDTH+2
  int last_g0 = -1;
  int idle0   = 0;
  always @(negedge clock) begin
    if (rst0_n) begin
      if (gnt0 != '0) begin
        chk("gap0_gnt", 32'(gnt0), 32'd1);
        if (last_g0 >= 0) begin
          chk("gap0_period", 32'(cyc - last_g0), 32'(WIDTH + 2));
          chk("gap0_idle",   32'(idle0), 32'd1);
        end
        last_g0 = cyc;
        idle0   = 0;
      end else if (!busy0) begin
        idle0++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    rst0_n    = 1'b0;
    want      = '0;
    for (int i = 0; i < N; i++) words[i] = '0;
    req0      = N'(1);
    data0     = '0;
    data0[WIDTH-1:0] = 8'h5A;
    hold_mode = 1'b0;
    idle_from = 0;
    ptr_m     = 0;
    clr_at    = -1;
    clr_idx   = 0;

    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset_n   = 1'b1;
    rst0_n    = 1'b1;
    idle_from = cyc;

    // Single requester, alternating word
    adv();
    words[0] = 8'hAA;
    want     = 4'b0001;
    model_eval();
    run(14);

    // All four held: strict rotation
    hold_mode = 1'b1;
    adv();
    words[0] = 8'hAA; words[1] = 8'hCC; words[2] = 8'hF0; words[3] = 8'h88;
    want = 4'b1111;
    model_eval();
    run(54);
    adv();
    want      = '0;
    hold_mode = 1'b0;
    model_eval();
    run(14);

    // Drive pointer to 2, then wrap to requester 0 and continue to 1
    adv();
    want     = 4'b0010;
    words[1] = 8'h11;
    model_eval();
    run(12);
    adv();
    want     = 4'b0011;
    words[0] = 8'h22;
    words[1] = 8'h33;
    model_eval();
    run(26);

    // Reset in the middle of a shift: frame aborted, pointer back to 0
    adv();
    want     = 4'b0100;
    words[2] = 8'h80;
    model_eval();
    repeat (5) adv();
    reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    ptr_m  = 0;
    clr_at = -1;
    adv();
    reset_n   = 1'b1;
    idle_from = cyc;
    want      = 4'b1100;
    words[2]  = 8'h80;
    words[3]  = 8'h3C;
    model_eval();
    run(26);

    // Short request pulse on 3 during requester 0's frame is never granted
    adv();
    want     = 4'b0001;
    words[0] = 8'h96;
    model_eval();
    run(3);
    adv();
    want[3]  = 1'b1;
    words[3] = 8'h77;
    model_eval();
    run(1);
    adv();
    want[3] = 1'b0;
    model_eval();
    run(14);

    // Random requesters
    repeat (1500) begin
      adv();
      for (int i = 0; i < N; i++) begin
        if (!want[i]) begin
          if ($urandom_range(3) == 0) begin
            want[i]  = 1'b1;
            words[i] = WIDTH'($urandom);
          end
        end else if (!(cyc == clr_at - 1 && i == clr_idx) && $urandom_range(39) == 0) begin
          want[i] = 1'b0;
        end
      end
      model_eval();
    end

    adv();
    want = '0;
    model_eval();
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0 && !mon_active) break;
      adv();
      model_eval();
    end
    chk("drain_queue",  32'(exp_q.size()), 32'd0);
    chk("drain_active", 32'(mon_active),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
